prefetch_issue_arbiter: RTL and testbench



---
 rtl/prefetch_issue_arbiter.sv | 108 ++++++++++
 tb/tb_prefetch_issue_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_issue_arbiter.sv
// prefetch_issue_arbiter
// Shares one downstream read-request issue channel among N prefetch streams.
// In IDLE a winner is picked by a descending rotating priority: indices below
// the last accepted winner come first, then the search wraps to the top of the
// vector. The winner's address is latched and held on a valid/ready port until
// it is accepted. A one-cycle grant pulse then goes back to that stream.

module prefetch_issue_arbiter #(
    parameter int IDX_WIDTH  = 3,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 resetN,
    input  logic [(1<<IDX_WIDTH)-1:0]            req,
    input  logic [(1<<IDX_WIDTH)*ADDR_WIDTH-1:0] reqAddr,
    output logic                                 outValid,
    input  logic                                 outReady,
    output logic [ADDR_WIDTH-1:0]                outAddr,
    output logic [IDX_WIDTH-1:0]                 outId,
    output logic [(1<<IDX_WIDTH)-1:0]            grant,
    output logic                                 busy
);

    localparam int N = 1 << IDX_WIDTH;
    localparam logic [N-1:0] ONE_HOT_ZERO = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   lastIdx;

    logic [N-1:0]           effReq;
    logic [N-1:0]           maskedReq;
    logic                   hasMasked;
    logic                   anyReq;
    logic [IDX_WIDTH-1:0]   winner;
    logic [ADDR_WIDTH-1:0]  selAddr;

    // Winner selection: drop the stream being granted this cycle (it cannot
    // have lowered req yet), prefer indices strictly below lastIdx, and take
    // the highest set bit of whichever vector is used.
    always_comb begin
        effReq    = req & ~grant;
        maskedReq = '0;
        for (int i = 0; i < N; i++) begin
            if (i < int'(lastIdx)) begin
                maskedReq[i] = effReq[i];
            end
        end
        hasMasked = |maskedReq;
        anyReq    = |effReq;
        winner    = '0;
        for (int i = 0; i < N; i++) begin
            if (hasMasked ? maskedReq[i] : effReq[i]) begin
                winner = IDX_WIDTH'(i);
            end
        end
        selAddr = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == IDX_WIDTH'(i)) begin
                selAddr = reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Issue FSM with registered outputs; reset wins over everything, including an open handshake.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state    <= IDLE;
            outValid <= 1'b0;
            outAddr  <= '0;
            outId    <= '0;
            grant    <= '0;
            lastIdx  <= '0;
        end else begin
            grant <= '0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        outId    <= winner;
                        outAddr  <= selAddr;
                        outValid <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (outValid && outReady) begin
                        grant    <= ONE_HOT_ZERO << outId;
                        lastIdx  <= outId;
                        outValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    outValid <= 1'b0;
                end
            endcase
        end
    end

    // busy is a plain decode of the state register.
    assign busy = (state == ISSUE);

endmodule

// File: tb/tb_prefetch_issue_arbiter.sv
// Testbench for prefetch_issue_arbiter: directed scenarios with literal
// expectations plus a randomized phase. A transaction-level model predicts every
// output on every cycle.

module tb_prefetch_issue_arbiter;

    localparam int IW = 3;
    localparam int AW = 32;
    localparam int N  = 1 << IW;

    logic            clk;
    logic            resetN;
    logic [N-1:0]    req;
    logic [N*AW-1:0] reqAddr;
    logic            outValid;
    logic            outReady;
    logic [AW-1:0]   outAddr;
    logic [IW-1:0]   outId;
    logic [N-1:0]    grant;
    logic            busy;

    int total = 0;
    int bad   = 0;

    int expSeq[$];

    prefetch_issue_arbiter #(.IDX_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .req      (req),
        .reqAddr  (reqAddr),
        .outValid (outValid),
        .outReady (outReady),
        .outAddr  (outAddr),
        .outId    (outId),
        .grant    (grant),
        .busy     (busy)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    // Reference model state: what the outputs must be after each edge.
    logic            expValid;
    logic [IW-1:0]   expId;
    logic [AW-1:0]   expAddr;
    logic [N-1:0]    expGrant;
    int              expLast;
    bit              modelReady = 1'b0;

    // Rotational search: start just below the last winner and walk down, wrapping at 0.
    function automatic int pickWinner(input logic [N-1:0] pend, input int last);
        int pick = -1;
        for (int k = 1; k <= N; k++) begin
            int idx = (last - k + N) % N;
            if (pick < 0 && pend[idx]) pick = idx;
        end
        return pick;
    endfunction

    function automatic int oneHotIdx(input logic [N-1:0] v);
        int idx = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i]) idx = i;
        return idx;
    endfunction

    // Transaction-level model, advanced on every rising edge.
    always @(posedge clk) begin
        if (!resetN) begin
            expValid   <= 1'b0;
            expId      <= '0;
            expAddr    <= '0;
            expGrant   <= '0;
            expLast    <= 0;
            modelReady <= 1'b1;
        end else if (modelReady) begin
            expGrant <= '0;
            if (expValid) begin
                if (outReady) begin
                    expGrant <= {{(N-1){1'b0}}, 1'b1} << expId;
                    expLast  <= int'(expId);
                    expValid <= 1'b0;
                end
            end else if (pickWinner(req & ~expGrant, expLast) >= 0) begin
                expValid <= 1'b1;
                expId    <= IW'(pickWinner(req & ~expGrant, expLast));
                expAddr  <= reqAddr[pickWinner(req & ~expGrant, expLast)*AW +: AW];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("modelValid", outValid, expValid);
            checkOutput("modelBusy",  busy,     expValid);
            checkOutput("modelGrant", grant,    expGrant);
            if (expValid) begin
                checkOutput("modelId",   outId,   expId);
                checkOutput("modelAddr", outAddr, expAddr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] reqV, input logic readyV);
        req      = reqV;
        outReady = readyV;
    endtask

    task automatic doReset();
        resetN = 1'b0;
        applyStimulus('0, 1'b0);
        tick();
        tick();
        resetN = 1'b1;
    endtask

    // Watch grants, check their order against expSeq and drop each granted bit.
    task automatic runUntilDrained(input int budget);
        int cyc = 0;
        while (expSeq.size() > 0 && cyc < budget) begin
            tick();
            cyc++;
            if (grant != '0) begin
                int g = oneHotIdx(grant);
                checkOutput("grantOrder", g, expSeq[0]);
                void'(expSeq.pop_front());
                if (g >= 0) req[g] = 1'b0;
            end
        end
        if (expSeq.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL grantTimeout actual=%0d_pending required=0_pending", expSeq.size());
            expSeq.delete();
        end
    endtask

    // Randomized requesters: hold until granted, release 0 or 1 cycle later.
    task automatic randomPhase(input int cycles);
        logic [N-1:0] clearNext = '0;
        logic [N-1:0] nreq;
        for (int c = 0; c < cycles; c++) begin
            tick();
            nreq      = req & ~clearNext;
            clearNext = '0;
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    if ($urandom_range(1) == 0) nreq[i] = 1'b0;
                    else clearNext[i] = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!nreq[i] && !grant[i] && !clearNext[i] && $urandom_range(3) == 0) nreq[i] = 1'b1;
                if ($urandom_range(1) == 0) reqAddr[i*AW +: AW] = $urandom;
            end
            if ($urandom_range(63) == 0) nreq[$urandom_range(N-1)] = 1'b0;
            req      = nreq;
            outReady = ($urandom_range(9) < 7);
            resetN   = ($urandom_range(299) != 0);
            if (!resetN) clearNext = '0;
        end
    endtask

    initial begin
        resetN   = 1'b0;
        req      = '0;
        reqAddr  = '0;
        outReady = 1'b0;

        // Reset then idle.
        doReset();
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("idleValid", outValid, 0);
            checkOutput("idleGrant", grant, 0);
            checkOutput("idleId",    outId, 0);
            checkOutput("idleAddr",  outAddr, 0);
            checkOutput("idleBusy",  busy, 0);
        end

        // Single requester.
        reqAddr[4*AW +: AW] = 32'h1000_0040;
        applyStimulus(8'b0001_0000, 1'b1);
        tick();
        checkOutput("singleValid", outValid, 1);
        checkOutput("singleId",    outId, 4);
        checkOutput("singleAddr",  outAddr, 32'h1000_0040);
        tick();
        checkOutput("singleGrant", grant, 8'b0001_0000);
        req[4] = 1'b0;
        tick();
        checkOutput("singleGrantOff", grant, 0);

        // Round robin from a fresh lastIdx.
        doReset();
        applyStimulus(8'b1001_1100, 1'b1);
        expSeq = '{7, 4, 3, 2};
        runUntilDrained(40);

        // Wrap-around, lastIdx is now 2.
        applyStimulus(8'b0100_0011, 1'b1);
        expSeq = '{1, 0, 6};
        runUntilDrained(40);

        // Backpressure on winner 5.
        reqAddr[5*AW +: AW] = 32'hA5A5_0005;
        applyStimulus(8'b0010_0000, 1'b0);
        tick();
        checkOutput("bpValid", outValid, 1);
        checkOutput("bpId",    outId, 5);
        checkOutput("bpAddr",  outAddr, 32'hA5A5_0005);
        reqAddr[5*AW +: AW] = 32'hDEAD_BEEF;
        reqAddr[7*AW +: AW] = 32'h7777_0007;
        req[7] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("bpHoldValid", outValid, 1);
            checkOutput("bpHoldId",    outId, 5);
            checkOutput("bpHoldAddr",  outAddr, 32'hA5A5_0005);
            checkOutput("bpHoldGrant", grant, 0);
        end
        outReady = 1'b1;
        tick();
        checkOutput("bpGrant", grant, 8'b0010_0000);
        req[5] = 1'b0;
        tick();
        checkOutput("bpNextValid", outValid, 1);
        checkOutput("bpNextId",    outId, 7);
        checkOutput("bpNextAddr",  outAddr, 32'h7777_0007);
        tick();
        checkOutput("bpNextGrant", grant, 8'b1000_0000);
        applyStimulus('0, 1'b0);

        // Reset in the middle of an issue.
        applyStimulus(8'b0000_1000, 1'b0);
        tick();
        checkOutput("midValid", outValid, 1);
        checkOutput("midId",    outId, 3);
        resetN = 1'b0;
        tick();
        checkOutput("rstValid", outValid, 0);
        checkOutput("rstGrant", grant, 0);
        checkOutput("rstId",    outId, 0);
        checkOutput("rstAddr",  outAddr, 0);
        checkOutput("rstBusy",  busy, 0);
        resetN = 1'b1;
        applyStimulus(8'b1111_1111, 1'b1);
        tick();
        checkOutput("postRstValid", outValid, 1);
        checkOutput("postRstId",    outId, 7);
        expSeq = '{7, 6, 5, 4, 3, 2, 1, 0};
        runUntilDrained(60);

        // Randomized traffic against the model.
        randomPhase(3000);
        resetN = 1'b1;
        applyStimulus('0, 1'b1);
        for (int c = 0; c < 6; c++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
